boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Synthesizable successor to the CPU bring-up sequence, parametrised in address width, data width, reset-hold length, run timeout and result-window size.
- Sequence: stream a program image into the `control` core's memory, hold the core in reset, enable it, wait for halt or timeout, then stream back a window of memory as results.
- Sits between a host/loader interface and the `control` core's reset, enable and memory port.

Parameters:
- ADDR_W, 8: memory address width; depth = 2**ADDR_W words.
- DATA_W, 32: memory and stream word width.
- RST_HOLD, 2: cycles `cpu_rst` stays asserted after the load completes (1..255).
- TIMEOUT, 65535: maximum RUN cycles before fault; 0 disables the timeout.
- RB_BASE, 16: first address of the result window.
- RB_COUNT, 4: number of result words (1..2**ADDR_W - RB_BASE).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: pulse; begins a load. Honoured only in IDLE, DONE, FAULT.
- `abort` in 1: level; forces IDLE on the next edge from any state.
- `ld_valid` in 1: program word valid.
- `ld_ready` out 1: block accepts a program word.
- `ld_data` in DATA_W: program word.
- `ld_last` in 1: marks the final program word.
- `mem_own` out 1: block owns the memory port. High in LOAD and DUMP.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: write data.
- `mem_rdata` in DATA_W: read data, valid one cycle after `mem_en` with `!mem_we`.
- `cpu_rst` out 1: active-high reset to the core.
- `cpu_enable` out 1: run enable to the core.
- `cpu_halt` in 1: core executed HLT; level.
- `dump_valid` out 1: result word valid.
- `dump_ready` in 1: result consumer ready.
- `dump_data` out DATA_W: result word.
- `dump_last` out 1: marks the final result word.
- `done` out 1: sequence completed.
- `fault` out 1: sequence failed.
- `err_code` out 2: fault cause. 0 = none, 1 = image overflow, 2 = timeout.
- `word_count` out ADDR_W+1: number of program words loaded.

Behaviour:
- Reset (`rst`=0 at edge): state IDLE.
  - `cpu_rst`=1; all other outputs 0; counters 0; `err_code`=0.
- IDLE: `cpu_rst`=1, `cpu_enable`=0. `start` → LOAD, with the address and `word_count` cleared.
- LOAD: `ld_ready`=1 and `mem_own`=1.
  - On each `ld_valid`&&`ld_ready`: combinationally drive `mem_en`=`mem_we`=1, `mem_addr`=current address, `mem_wdata`=`ld_data`.
  - Same edge: address++ and `word_count`++.
  - Accepted word with `ld_last` → HOLD.
  - Accepted word at address 2**ADDR_W-1 without `ld_last` → FAULT, `err_code`=1. That word is written; the address does not wrap.
- HOLD: `cpu_rst`=1, `cpu_enable`=0 for exactly RST_HOLD cycles, then RUN.
- RUN: `cpu_rst`=0, `cpu_enable`=1. Cycle counter increments every cycle.
  - `cpu_halt`=1 → DUMP; `cpu_enable` drops on the next edge.
  - Counter == TIMEOUT-1 with no halt → FAULT, `err_code`=2.
  - Halt and timeout in the same cycle: halt wins.
- DUMP: `mem_own`=1, `cpu_enable`=0, `cpu_rst`=0. Per word, sub-phases RD then WT:
  - RD: issue a read, `mem_en`=1, `mem_we`=0, `mem_addr`=RB_BASE+i.
  - WT: next cycle, capture `mem_rdata` into the output register; `dump_valid`=1.
  - Hold `dump_valid` and `dump_data` stable until `dump_ready`. On handshake, start the next read in the same cycle.
  - Throughput: 1 word per 2 cycles when `dump_ready` is high.
  - `dump_last`=1 with word RB_COUNT-1. Its handshake → DONE.
- DONE: `done`=1, `cpu_rst`=1. `start` → LOAD and clears `done`.
- FAULT: `fault`=1, `cpu_rst`=1, `err_code` held. `start` → LOAD and clears `fault` and `err_code`.
- `start` in LOAD, HOLD, RUN or DUMP is ignored.
- `abort` has priority over every transition. The next state is IDLE with IDLE outputs; any partial dump is dropped; `word_count` is preserved.
- `rst` has priority over `abort`.
- `ld_ready`=0 outside LOAD. The memory port is idle (`mem_en`=0) whenever `mem_own`=0.
- `word_count` saturates only by construction: the maximum is 2**ADDR_W.

Decomposition:
- Shared package (`boot_pkg`): the state enumeration, ERR_NONE/ERR_OVF/ERR_TMO constants and the `err_code` width.
- One natural sub-module, `dump_reader`: the 2-phase read/handshake engine with output register. It takes base, count and a go strobe, and returns a finished pulse.
- The FSM, load path and run counter stay in `boot_sequencer`.

Test Plan:
- Image and result window: stream 6 words (MV $10,%r1; MV $5,%r2; ADD; STW &16; LDW &16,%r8; HLT), `ld_last` on word 6.
  - Mem writes go to addresses 0..5 and `word_count`=6.
  - `cpu_rst` is high for 2 cycles, then `cpu_enable`=1.
  - A core model halts; dump of addresses 16..19 returns 15 first, `dump_last` on the 4th word, `done`=1.
- Overflow: ADDR_W=3, stream 9 words with no `ld_last` → 8 writes (addresses 0..7), `fault`=1, `err_code`=1, `cpu_enable` never 1, 9th word not accepted.
- Timeout: TIMEOUT=20, `cpu_halt` held 0 → exactly 20 cycles with `cpu_enable`=1, then `fault`=1, `err_code`=2, `cpu_rst`=1.
- Backpressure: `dump_ready` low for 5 cycles on word 2 → `dump_data` stable throughout and no extra reads issued. Total words = RB_COUNT.
- Abort and reset: `abort` mid-RUN → next cycle IDLE, `cpu_enable`=0, `cpu_rst`=1. `rst`=0 mid-DUMP → all outputs return to reset values at that edge. A subsequent `start` reloads cleanly.
- Same-cycle events: `cpu_halt` and timeout in the same cycle → DUMP, not FAULT. `start` during LOAD → ignored, address unchanged.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer and its dump engine.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_DUMP,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_RD,
    PH_WT
  } phase_t;

  localparam int ERR_W = 2;
  localparam logic [ERR_W-1:0] ERR_NONE = 2'd0;
  localparam logic [ERR_W-1:0] ERR_OVF  = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TMO  = 2'd2;

  // Shared hold/run cycle counter width; wide enough for any 32-bit TIMEOUT.
  localparam int CNT_W = 32;

endpackage

// File: rtl/dump_reader.sv
// Two-phase result reader: issue a read, then present the returned word on a
// valid/ready stream until accepted. Pulses finished on the last handshake.
module dump_reader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              go,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              finished
);

  phase_t            phase_q, phase_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q;
  logic              held_q;
  logic              last_word;

  assign last_word = (idx_q == count - 1'b1);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    phase_d    = phase_q;
    idx_d      = idx_q;
    mem_en     = 1'b0;
    mem_addr   = '0;
    dump_valid = 1'b0;
    dump_data  = '0;
    dump_last  = 1'b0;
    finished   = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (go) begin
          phase_d = PH_RD;
          idx_d   = '0;
        end
      end
      PH_RD: begin
        mem_en   = 1'b1;
        mem_addr = base + idx_q[ADDR_W-1:0];
        phase_d  = PH_WT;
      end
      PH_WT: begin
        // Read data arrives this cycle; afterwards the captured copy is shown.
        dump_valid = 1'b1;
        dump_data  = held_q ? data_q : mem_rdata;
        dump_last  = last_word;
        if (dump_ready) begin
          if (last_word) begin
            finished = 1'b1;
            phase_d  = PH_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            phase_d = PH_RD;
          end
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    if (clear) phase_d = PH_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= PH_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      held_q  <= (phase_q == PH_WT) && (phase_d == PH_WT);
      if (phase_q == PH_WT && !held_q) data_q <= mem_rdata;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// CPU bring-up sequencer: load an image into core memory, pulse core reset,
// run until halt or timeout, then stream back a window of results.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RST_HOLD = 2,
  parameter int TIMEOUT  = 65535,
  parameter int RB_BASE  = 16,
  parameter int RB_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_own,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rst,
  output logic              cpu_enable,
  input  logic              cpu_halt,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              done,
  output logic              fault,
  output logic [ERR_W-1:0]  err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam int                WC_W      = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] RB_ADDR   = ADDR_W'(RB_BASE);
  localparam logic [WC_W-1:0]   RB_CNT    = WC_W'(RB_COUNT);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam bit                TMO_EN    = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;

  logic              rd_go, rd_en, rd_finished;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_go      = (state_q == ST_RUN) && cpu_halt && !abort;
  assign err_code   = err_q;
  assign word_count = wc_q;

  dump_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_dump_reader (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .go        (rd_go),
    .base      (RB_ADDR),
    .count     (RB_CNT),
    .mem_en    (rd_en),
    .mem_addr  (rd_addr),
    .mem_rdata (mem_rdata),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_data (dump_data),
    .dump_last (dump_last),
    .finished  (rd_finished)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wc_d       = wc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ld_ready   = 1'b0;
    mem_own    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_rst    = 1'b1;
    cpu_enable = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        done  = (state_q == ST_DONE);
        fault = (state_q == ST_FAULT);
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          wc_d    = '0;
          err_d   = ERR_NONE;
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        mem_own  = 1'b1;
        mem_addr = addr_q;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          wc_d      = wc_q + 1'b1;
          // The top word is written but the address never wraps back to 0.
          if (addr_q != ADDR_MAX) addr_d = addr_q + 1'b1;
          if (ld_last) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else if (addr_q == ADDR_MAX) begin
            state_d = ST_FAULT;
            err_d   = ERR_OVF;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cpu_rst    = 1'b0;
        cpu_enable = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        // A halt seen on the timeout cycle still counts as a clean finish.
        if (cpu_halt) begin
          state_d = ST_DUMP;
        end else if (TMO_EN && cnt_q == TMO_LAST) begin
          state_d = ST_FAULT;
          err_d   = ERR_TMO;
        end
      end
      ST_DUMP: begin
        cpu_rst  = 1'b0;
        mem_own  = 1'b1;
        mem_en   = rd_en;
        mem_addr = rd_addr;
        if (rd_finished) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: a memory plus tiny core model on the main
// instance, and a 3-bit-address instance for the image-overflow case.
module tb_boot_sequencer;
  import boot_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, ld_valid, ld_last, dump_ready, force_halt;
  logic [DW-1:0] ld_data, mem_rdata, mem_wdata, dump_data;
  logic          ld_ready, mem_own, mem_en, mem_we, cpu_rst, cpu_enable, cpu_halt;
  logic          dump_valid, dump_last, done, fault;
  logic [AW-1:0] mem_addr;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;

  boot_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .RST_HOLD(2), .TIMEOUT(20), .RB_BASE(16), .RB_COUNT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .mem_own(mem_own), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_rst(cpu_rst), .cpu_enable(cpu_enable), .cpu_halt(cpu_halt),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_last(dump_last), .done(done), .fault(fault), .err_code(err_code),
    .word_count(word_count)
  );

  // Overflow instance: 8-word memory, timeout disabled.
  logic          o_start, o_ld_valid, o_ld_last, o_zero;
  logic [DW-1:0] o_ld_data, o_mem_wdata, o_dump_data;
  logic          o_ld_ready, o_mem_own, o_mem_en, o_mem_we, o_cpu_rst, o_cpu_enable;
  logic          o_dump_valid, o_dump_last, o_done, o_fault, o_en_seen;
  logic [2:0]    o_mem_addr;
  logic [1:0]    o_err_code;
  logic [3:0]    o_word_count;
  assign o_zero = 1'b0;

  boot_sequencer #(
    .ADDR_W(3), .DATA_W(DW), .RST_HOLD(2), .TIMEOUT(0), .RB_BASE(0), .RB_COUNT(2)
  ) dut_ovf (
    .clk(clk), .rst(rst), .start(o_start), .abort(o_zero),
    .ld_valid(o_ld_valid), .ld_ready(o_ld_ready), .ld_data(o_ld_data), .ld_last(o_ld_last),
    .mem_own(o_mem_own), .mem_en(o_mem_en), .mem_we(o_mem_we), .mem_addr(o_mem_addr),
    .mem_wdata(o_mem_wdata), .mem_rdata(32'h0),
    .cpu_rst(o_cpu_rst), .cpu_enable(o_cpu_enable), .cpu_halt(o_zero),
    .dump_valid(o_dump_valid), .dump_ready(1'b1), .dump_data(o_dump_data),
    .dump_last(o_dump_last), .done(o_done), .fault(o_fault), .err_code(o_err_code),
    .word_count(o_word_count)
  );

  always @(posedge clk) begin
    if (!rst) o_en_seen <= 1'b0;
    else if (o_cpu_enable) o_en_seen <= 1'b1;
  end

  // Memory and core model. Opcodes: 01 MV imm,rd; 02 ADD rs1,rs2,rd;
  // 03 STW rs,&a; 04 LDW &a,rd; FF HLT; anything else is a no-op.
  logic [DW-1:0] mem  [0:255];
  logic [DW-1:0] regs [0:15];
  logic [AW-1:0] pc;
  logic          halted;
  logic [DW-1:0] ins;
  int            rd_count = 0;

  assign ins      = mem[pc];
  assign cpu_halt = halted | force_halt;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
      pc        <= '0;
      halted    <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (mem_own && mem_en) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else begin
          mem_rdata <= mem[mem_addr];
          rd_count  <= rd_count + 1;
        end
      end
      if (cpu_rst) begin
        pc     <= '0;
        halted <= 1'b0;
      end else if (cpu_enable && !halted) begin
        pc <= pc + 1'b1;
        case (ins[31:24])
          8'h01:   regs[ins[19:16]] <= {16'h0, ins[15:0]};
          8'h02:   regs[ins[19:16]] <= regs[ins[11:8]] + regs[ins[3:0]];
          8'h03:   mem[ins[7:0]] <= regs[ins[19:16]];
          8'h04:   regs[ins[19:16]] <= mem[ins[7:0]];
          8'hFF:   halted <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] prog [6];
  logic [DW-1:0] nops [6];
  logic [DW-1:0] exp_dump [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic at_mid();
    @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; returns just after the edge that enters LOAD + 1.
  task automatic start_load();
    start = 1'b1;
    after_edge();
    start = 1'b0;
    at_mid();
    check("load_ready", ld_ready, 1'b1);
    check("load_clears_done_fault", {done, fault, err_code}, 4'b0000);
    after_edge();
  endtask

  task automatic load6(input bit use_prog);
    logic [DW-1:0] w;
    for (int i = 0; i < 6; i++) begin
      w        = use_prog ? prog[i] : nops[i];
      ld_valid = 1'b1;
      ld_last  = (i == 5);
      ld_data  = w;
      at_mid();
      check("load_strobe", {mem_en, mem_we}, 2'b11);
      check("load_addr", mem_addr, 64'(i));
      check("load_wdata", mem_wdata, w);
      after_edge();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc0;
    bit got;
    rst = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_data = '0; dump_ready = 1'b1; force_halt = 1'b0;
    o_start = 1'b0; o_ld_valid = 1'b0; o_ld_last = 1'b0; o_ld_data = '0;
    prog[0] = 32'h0101_000A;  // MV $10,%r1
    prog[1] = 32'h0102_0005;  // MV $5,%r2
    prog[2] = 32'h0203_0102;  // ADD %r1,%r2 -> %r3
    prog[3] = 32'h0303_0010;  // STW %r3,&16
    prog[4] = 32'h0408_0010;  // LDW &16,%r8
    prog[5] = 32'hFF00_0000;  // HLT
    nops[0] = 32'h0101_0001;
    for (int i = 1; i < 6; i++) nops[i] = 32'h0;
    exp_dump[0] = 32'd15;
    exp_dump[1] = 32'hA000_0011;
    exp_dump[2] = 32'hA000_0012;
    exp_dump[3] = 32'hA000_0013;

    // Reset values
    after_edge();
    after_edge();
    at_mid();
    check("rst_cpu_rst", cpu_rst, 1'b1);
    check("rst_zero_outs", {cpu_enable, ld_ready, mem_own, mem_en, mem_we, dump_valid,
                            dump_last, done, fault}, 9'b0);
    check("rst_err_wc", {err_code, word_count}, 11'b0);
    after_edge();
    rst = 1'b1;

    // Image overflow on the 3-bit instance
    o_start = 1'b1;
    after_edge();
    o_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      o_ld_valid = 1'b1;
      o_ld_data  = 32'hB000_0000 + i;
      at_mid();
      if (i < 8) begin
        check("ovf_write", {o_mem_en, o_mem_we}, 2'b11);
        check("ovf_addr", o_mem_addr, 64'(i));
      end else begin
        check("ovf_9th_refused", {o_ld_ready, o_mem_en}, 2'b00);
      end
      after_edge();
    end
    o_ld_valid = 1'b0;
    at_mid();
    check("ovf_fault", {o_fault, o_err_code}, 3'b101);
    check("ovf_word_count", o_word_count, 4'd8);
    check("ovf_never_enabled", {o_en_seen, o_cpu_enable, o_cpu_rst}, 3'b001);
    after_edge();

    // Program load with an ignored start and an idle gap
    start = 1'b1;
    after_edge();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        ld_valid = 1'b0;
        start    = 1'b1;
        at_mid();
        check("gap_no_write", mem_en, 1'b0);
        check("gap_addr_held", mem_addr, 64'd3);
        after_edge();
        start = 1'b0;
      end
      ld_valid = 1'b1;
      ld_last  = (i == 5);
      ld_data  = prog[i];
      at_mid();
      check("img_strobe", {mem_en, mem_we, ld_ready}, 3'b111);
      check("img_addr", mem_addr, 64'(i));
      check("img_wdata", mem_wdata, prog[i]);
      after_edge();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    at_mid();
    check("img_word_count", word_count, 9'd6);
    check("hold1", {cpu_rst, cpu_enable, ld_ready}, 3'b100);
    after_edge();
    at_mid();
    check("hold2", {cpu_rst, cpu_enable}, 2'b10);
    after_edge();
    at_mid();
    check("run_entry", {cpu_rst, cpu_enable, mem_own}, 3'b010);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      after_edge();
      at_mid();
      if (!cpu_enable) break;
      n++;
    end
    check("run_cycles_to_halt", 64'(n), 64'd7);
    check("dump_first_read", {mem_own, mem_en, mem_we, dump_valid, cpu_rst}, 5'b11000);
    check("dump_first_addr", mem_addr, 64'd16);
    rc0 = rd_count;

    // Result stream with backpressure on the second word
    for (int w = 0; w < 4; w++) begin
      n = 0;
      do begin
        after_edge();
        if (w == 1) dump_ready = 1'b0;
        at_mid();
        n++;
      end while (!dump_valid && n < 10);
      check("dump_valid_seen", dump_valid, 1'b1);
      check("dump_data", dump_data, exp_dump[w]);
      check("dump_last", dump_last, 1'(w == 3));
      if (w == 1) begin
        for (int k = 0; k < 4; k++) begin
          after_edge();
          at_mid();
          check("bp_stable", {dump_valid, dump_data}, {1'b1, exp_dump[1]});
          check("bp_no_read", mem_en, 1'b0);
        end
        after_edge();
        dump_ready = 1'b1;
        at_mid();
        check("bp_release", dump_data, exp_dump[1]);
      end
    end
    after_edge();
    at_mid();
    check("done_state", {done, fault, cpu_rst, dump_valid, mem_own}, 5'b10100);
    check("dump_read_count", 64'(rd_count - rc0), 64'd4);
    after_edge();

    // Timeout: no HLT in the image
    start_load();
    load6(1'b0);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      at_mid();
      if (cpu_enable) n++;
      if (fault) break;
      after_edge();
    end
    check("tmo_enable_cycles", 64'(n), 64'd20);
    check("tmo_fault", {fault, err_code, cpu_rst, cpu_enable}, 5'b11010);
    after_edge();

    // Halt on the timeout cycle wins
    start_load();
    load6(1'b0);
    at_mid();
    after_edge();
    at_mid();
    after_edge();
    at_mid();
    check("sc_run_c1", cpu_enable, 1'b1);
    for (int k = 0; k < 18; k++) begin
      after_edge();
      at_mid();
    end
    after_edge();
    force_halt = 1'b1;
    at_mid();
    check("sc_run_c20", cpu_enable, 1'b1);
    after_edge();
    force_halt = 1'b0;
    at_mid();
    check("sc_dump_not_fault", {fault, cpu_enable, mem_en, mem_we}, 4'b0010);
    check("sc_dump_addr", mem_addr, 64'd16);
    for (int k = 0; k < 40; k++) begin
      after_edge();
      at_mid();
      if (done) break;
    end
    check("sc_done", {done, fault, err_code}, 4'b1000);
    after_edge();

    // Abort during RUN
    start_load();
    load6(1'b0);
    at_mid();
    after_edge();
    at_mid();
    after_edge();
    abort = 1'b1;
    at_mid();
    check("abort_pre_edge", cpu_enable, 1'b1);
    after_edge();
    abort = 1'b0;
    at_mid();
    check("abort_idle", {cpu_enable, cpu_rst, mem_own, ld_ready, done, fault}, 6'b010000);
    check("abort_wc_kept", word_count, 9'd6);
    after_edge();

    // Reset during DUMP, then a clean reload
    start_load();
    dump_ready = 1'b0;
    load6(1'b1);
    for (int k = 0; k < 60; k++) begin
      at_mid();
      if (dump_valid) break;
      after_edge();
    end
    check("rd_dump_reached", {dump_valid, dump_data}, {1'b1, 32'd15});
    after_edge();
    rst = 1'b0;
    after_edge();
    at_mid();
    check("rd_reset_outs", {cpu_rst, cpu_enable, dump_valid, mem_own, mem_en, ld_ready,
                            done, fault}, 8'b10000000);
    check("rd_reset_regs", {err_code, word_count}, 11'b0);
    after_edge();
    rst = 1'b1;
    dump_ready = 1'b1;
    start_load();
    load6(1'b1);
    got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      at_mid();
      if (dump_valid && !got) begin
        check("reload_first_word", dump_data, 32'd15);
        got = 1'b1;
      end
      if (done) break;
      after_edge();
    end
    check("reload_done", {done, got}, 2'b11);
    check("reload_wc", word_count, 9'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
